// File: rtl/modn_down_timer.sv
// Loadable mod-N down-counter/timer: counts a loaded value down to 0, then either
// wraps to N-1 (periodic) or halts at 0 (one-shot), with a one-cycle terminal-count pulse.
module modn_down_timer #(
    parameter int N     = 16,
    parameter int width = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             mode,
    output logic [width-1:0] count,
    output logic             tc,
    output logic             busy
);

    // state | meaning
    // IDLE  | after reset, count parked at N-1, en ignored
    // RUN   | counting down while en is high
    // HALT  | one-shot expired, count parked at 0 until load or rst

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [width-1:0] max_val = width'(N - 1);

    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= max_val;
            tc    <= 1'b0;
            busy  <= 1'b0;
        end else if (load) begin
            // Load beats an expiry on the same edge, so no tc and no HALT entry.
            count <= (load_val > max_val) ? max_val : load_val;
            state <= RUN;
            busy  <= 1'b1;
            tc    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!en) begin
                        tc <= 1'b0;
                    end else if (count != '0) begin
                        count <= count - width'(1);
                        tc    <= 1'b0;
                    end else if (!mode) begin
                        count <= max_val;
                        tc    <= 1'b1;
                    end else begin
                        tc    <= 1'b1;
                        state <= HALT;
                        busy  <= 1'b0;
                    end
                end
                IDLE, HALT: begin
                    tc <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    count <= max_val;
                    tc    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
